// File: rtl/dram_controller.sv
// Fast-page-mode DRAM controller for one 16 MB, 32-bit SIMM bank.
// Sequences RAS/CAS with a row/column address mux, byte-lane write strobes and CAS-before-RAS refresh.
module dram_controller #(
  parameter int unsigned REFRESH_DIV   = 780,
  parameter int unsigned RP_CYCLES     = 2,
  parameter int unsigned RF_RAS_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CS_DRAM_n,
  input  logic        AS_n,
  input  logic        DS_n,
  input  logic        RW,
  input  logic [1:0]  SIZ,
  input  logic [23:0] A,
  output logic [10:0] MA,
  output logic        RAS_n,
  output logic [3:0]  CAS_n,
  output logic        WE_n,
  output logic        DSACK0_DRAM_n,
  output logic        DSACK1_DRAM_n
);

  localparam int unsigned RC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned CNT_MAX = (RP_CYCLES > RF_RAS_CYCLES) ? RP_CYCLES : RF_RAS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_CAS, S_HOLD, S_RF_CAS, S_RF_RAS, S_PRE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      ma_q, ma_d;
  logic             ras_q, ras_d;
  logic [3:0]       cas_q, cas_d;
  logic             we_q, we_d;
  logic             ack_q, ack_d;
  logic             go_pre;
  logic             rf_dec;

  logic [RC_W-1:0]  rc_q;
  logic [1:0]       rf_pending_q;
  logic             rf_tick;

  logic [2:0]       lane_first, lane_last;
  logic [3:0]       off_en;
  logic [3:0]       wr_cas_n;

  // Write byte lanes: offsets A[1:0] .. min(3, A[1:0]+n-1), n = SIZ with 00 meaning 4
  always_comb begin
    off_en     = '0;
    lane_first = {1'b0, A[1:0]};
    lane_last  = lane_first + ((SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ}) - 3'd1;
    for (int k = 0; k < 4; k++) begin
      off_en[k] = (3'(k) >= lane_first) && (3'(k) <= lane_last);
    end
    wr_cas_n = ~{off_en[0], off_en[1], off_en[2], off_en[3]};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    ras_d   = ras_q;
    cas_d   = cas_q;
    we_d    = we_q;
    ack_d   = ack_q;
    go_pre  = 1'b0;
    rf_dec  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rf_pending_q != 2'd0) begin
          state_d = S_RF_CAS;
        end else if (!CS_DRAM_n && !AS_n) begin
          ma_d    = A[23:13];
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        if (AS_n) begin
          go_pre = 1'b1;
        end else begin
          ras_d   = 1'b0;
          state_d = S_COL;
        end
      end
      S_COL: begin
        if (AS_n) begin
          go_pre = 1'b1;
        end else begin
          ma_d    = A[12:2];
          we_d    = RW;
          state_d = S_CAS;
        end
      end
      S_CAS: begin
        if (AS_n) begin
          go_pre = 1'b1;
        end else if (RW || !DS_n) begin
          cas_d   = RW ? 4'b0000 : wr_cas_n;
          ack_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (AS_n) go_pre = 1'b1;
      end
      S_RF_CAS: begin
        cas_d   = 4'b0000;
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_RF_RAS;
      end
      S_RF_RAS: begin
        if (cnt_q == CNT_W'(RF_RAS_CYCLES)) begin
          rf_dec = 1'b1;
          go_pre = 1'b1;
        end else begin
          ras_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (cnt_q == CNT_W'(RP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every path into precharge releases all strobes and the acknowledge together
    if (go_pre) begin
      ras_d   = 1'b1;
      cas_d   = 4'b1111;
      we_d    = 1'b1;
      ack_d   = 1'b1;
      cnt_d   = '0;
      state_d = S_PRE;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      ras_q   <= 1'b1;
      cas_q   <= 4'b1111;
      we_q    <= 1'b1;
      ack_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
    end
  end

  assign rf_tick = (rc_q == RC_W'(REFRESH_DIV - 1));

  // Refresh interval counter and saturating backlog of owed refreshes
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rc_q         <= '0;
      rf_pending_q <= 2'd0;
    end else begin
      rc_q <= rf_tick ? '0 : rc_q + RC_W'(1);
      case ({rf_tick, rf_dec})
        2'b10:   if (rf_pending_q != 2'd3) rf_pending_q <= rf_pending_q + 2'd1;
        2'b01:   rf_pending_q <= rf_pending_q - 2'd1;
        default: rf_pending_q <= rf_pending_q;
      endcase
    end
  end

  assign MA            = ma_q;
  assign RAS_n         = ras_q;
  assign CAS_n         = cas_q;
  assign WE_n          = we_q;
  assign DSACK0_DRAM_n = ack_q;
  assign DSACK1_DRAM_n = ack_q;

endmodule

// File: tb/tb_dram_controller.sv
// Bench for dram_controller: directed CPU/refresh scenarios feed an expected-event queue,
// and a negedge monitor checks each strobe transition against it for cycle and content.
module tb_dram_controller;

  localparam int unsigned DIV = 200;
  localparam int K_ROW   = 0;
  localparam int K_ACK   = 1;
  localparam int K_CBR   = 2;
  localparam int K_RFRAS = 3;
  localparam int K_REL   = 4;

  logic        CLK;
  logic        RST_n;
  logic        CS_DRAM_n, AS_n, DS_n, RW;
  logic [1:0]  SIZ;
  logic [23:0] A;
  logic [10:0] MA;
  logic        RAS_n;
  logic [3:0]  CAS_n;
  logic        WE_n;
  logic        DSACK0_DRAM_n, DSACK1_DRAM_n;

  dram_controller #(.REFRESH_DIV(DIV), .RP_CYCLES(2), .RF_RAS_CYCLES(3)) dut (
    .CLK(CLK), .RST_n(RST_n), .CS_DRAM_n(CS_DRAM_n), .AS_n(AS_n), .DS_n(DS_n), .RW(RW),
    .SIZ(SIZ), .A(A), .MA(MA), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .DSACK0_DRAM_n(DSACK0_DRAM_n), .DSACK1_DRAM_n(DSACK1_DRAM_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [10:0] ma;
    logic [3:0]  cas;
    logic        we;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic string kname(int k);
    case (k)
      K_ROW:   return "row";
      K_ACK:   return "ack";
      K_CBR:   return "cbr";
      K_RFRAS: return "rf_ras";
      K_REL:   return "release";
      default: return "none";
    endcase
  endfunction

  task automatic push_ev(input int k, input int c, input logic [10:0] ma,
                         input logic [3:0] cas, input logic we);
    ev_t e;
    e.kind = k; e.cyc = c; e.ma = ma; e.cas = cas; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: classify each strobe transition and compare against the head of the queue
  logic       ras_p = 1'b1;
  logic [3:0] cas_p = 4'hF;
  logic [1:0] ack_p = 2'b11;
  logic [1:0] mon_ack;
  int         mon_k;
  logic       mon_ok;
  ev_t        mon_e;

  always @(negedge CLK) begin
    mon_ack = {DSACK1_DRAM_n, DSACK0_DRAM_n};
    mon_k   = -1;
    if (ras_p === 1'b0 && RAS_n === 1'b1)             mon_k = K_REL;
    else if (ras_p === 1'b1 && RAS_n === 1'b0)        mon_k = (CAS_n === 4'hF) ? K_ROW : K_RFRAS;
    else if (ack_p === 2'b11 && mon_ack !== 2'b11)    mon_k = K_ACK;
    else if (cas_p === 4'hF && CAS_n !== 4'hF && RAS_n === 1'b1) mon_k = K_CBR;

    if (mon_k >= 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected %s event at cycle %0d (MA=%h CAS_n=%b WE_n=%b DSACK=%b RAS_n=%b)",
                 kname(mon_k), cyc, MA, CAS_n, WE_n, mon_ack, RAS_n);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (mon_k == mon_e.kind) && (cyc == mon_e.cyc);
        case (mon_e.kind)
          K_ROW:   mon_ok = mon_ok && (MA === mon_e.ma);
          K_ACK:   mon_ok = mon_ok && (MA === mon_e.ma) && (CAS_n === mon_e.cas) &&
                            (WE_n === mon_e.we) && (mon_ack === 2'b00) && (RAS_n === 1'b0);
          K_CBR:   mon_ok = mon_ok && (CAS_n === 4'h0) && (WE_n === 1'b1) && (mon_ack === 2'b11);
          K_RFRAS: mon_ok = mon_ok && (CAS_n === 4'h0) && (mon_ack === 2'b11);
          default: mon_ok = mon_ok && (CAS_n === 4'hF) && (WE_n === 1'b1) && (mon_ack === 2'b11);
        endcase
        if (!mon_ok)
          $display("FAIL event %s: got %s@%0d MA=%h CAS_n=%b WE_n=%b DSACK=%b RAS_n=%b, expected %s@%0d MA=%h CAS_n=%b WE_n=%b",
                   kname(mon_e.kind), kname(mon_k), cyc, MA, CAS_n, WE_n, mon_ack, RAS_n,
                   kname(mon_e.kind), mon_e.cyc, mon_e.ma, mon_e.cas, mon_e.we);
        if (!mon_ok) n_bad++;
      end
    end
    ras_p = RAS_n;
    cas_p = CAS_n;
    ack_p = mon_ack;
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Issue one CPU cycle now; delay = IDLE-acceptance cycles lost to precharge/refresh.
  // hold < 0 leaves AS_n asserted in HOLD and returns at the acknowledge cycle.
  task automatic access(input logic rw, input logic [23:0] addr, input logic [1:0] siz,
                        input logic [3:0] cas_exp, input logic [10:0] row, input logic [10:0] col,
                        input int ds_wait, input int delay, input int hold, output int h);
    int p, e0, ack;
    p   = cyc;
    e0  = p + 1 + delay;
    ack = e0 + 3 + ds_wait;
    push_ev(K_ROW, e0 + 1, row, 4'hF, 1'b1);
    push_ev(K_ACK, ack, col, cas_exp, rw);
    A = addr; SIZ = siz; RW = rw;
    DS_n = (ds_wait > 0);
    CS_DRAM_n = 1'b0; AS_n = 1'b0;
    if (ds_wait > 0) begin
      step_to(ack - 1);
      DS_n = 1'b0;
    end
    if (hold < 0) begin
      step_to(ack);
      h = ack;
    end else begin
      push_ev(K_REL, ack + hold + 1, 11'h0, 4'hF, 1'b1);
      step_to(ack + hold);
      AS_n = 1'b1; CS_DRAM_n = 1'b1; DS_n = 1'b1;
      h = cyc;
    end
  endtask

  task automatic refresh_exp(input int r);
    push_ev(K_CBR,   r + 1, 11'h0, 4'h0, 1'b1);
    push_ev(K_RFRAS, r + 2, 11'h0, 4'h0, 1'b1);
    push_ev(K_REL,   r + 5, 11'h0, 4'hF, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, h, p, x;
    RST_n = 1'b0; CS_DRAM_n = 1'b1; AS_n = 1'b1; DS_n = 1'b1; RW = 1'b1;
    SIZ = 2'b00; A = 24'h0;

    step_to(2);
    check("reset outputs", {RAS_n, CAS_n, WE_n, DSACK0_DRAM_n, DSACK1_DRAM_n, MA},
          {1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 11'h000});
    RST_n = 1'b1;
    r0 = cyc;

    // Read long 0x80001234, then writes back-to-back to check 2-cycle precharge
    step_to(r0 + 2);
    access(1'b1, 24'h001234, 2'b00, 4'b0000, 11'h000, 11'h48D, 0, 0, 2, h);
    step_to(h + 1);
    access(1'b0, 24'h7FFFFE, 2'b01, 4'b1101, 11'h3FF, 11'h7FF, 0, 2, 0, h);
    step_to(h + 1);
    access(1'b0, 24'h123457, 2'b10, 4'b1110, 11'h091, 11'h515, 0, 2, 1, h);
    step_to(h + 1);
    access(1'b0, 24'h000001, 2'b00, 4'b1000, 11'h000, 11'h000, 0, 2, 0, h);

    // Write with DS_n late by 3 cycles
    step_to(h + 3);
    access(1'b0, 24'hFFE008, 2'b00, 4'b0000, 11'h7FF, 11'h002, 3, 0, 1, h);

    // Aborted cycle: AS_n negates while in ROW; no strobes, then precharge
    step_to(h + 3);
    p = cyc;
    A = 24'h055555; RW = 1'b1; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    step_to(p + 1);
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    step_to(p + 2);
    access(1'b1, 24'h0FFFFC, 2'b10, 4'b0000, 11'h07F, 11'h7FF, 0, 2, 0, h);

    // Refresh owed at the same time as a CPU request: CBR runs first
    step_to(r0 + DIV);
    refresh_exp(r0 + DIV + 1);
    access(1'b1, 24'h2468AC, 2'b00, 4'b0000, 11'h123, 11'h22B, 0, 8, 4 * DIV, h);

    // Four ticks during the long hold saturate at three refreshes
    refresh_exp(h + 4);
    refresh_exp(h + 12);
    refresh_exp(h + 20);
    step_to(h + 27);
    access(1'b1, 24'hABCDEF, 2'b00, 4'b0000, 11'h55E, 11'h37B, 0, 0, -1, h);

    // Asynchronous reset in the middle of HOLD
    step_to(h + 2);
    x = cyc;
    push_ev(K_REL, x, 11'h0, 4'hF, 1'b1);
    RST_n = 1'b0; AS_n = 1'b1; CS_DRAM_n = 1'b1; DS_n = 1'b1;
    #1;
    check("async reset outputs", {RAS_n, CAS_n, WE_n, DSACK0_DRAM_n, DSACK1_DRAM_n, MA},
          {1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 11'h000});
    step_to(x + 2);
    RST_n = 1'b1;
    access(1'b1, 24'h001234, 2'b00, 4'b0000, 11'h000, 11'h48D, 0, 0, 0, h);

    step_to(h + 6);
    check("expected events drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
